mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Parametrised, multi-cycle multiply/divide unit with architectural HI/LO registers, owned inside the unit.
- Sits beside the single-cycle ALU in the EX stage.
- The pipeline issues MULT/MULTU/DIV/DIVU/MTHI/MTLO through a start/busy/done handshake.
- HI/LO are read combinationally for MFHI/MFLO.
- Adds signed/unsigned modes, iterative shift-add / restoring-divide datapaths, divide-by-zero handling and stall signalling.

Parameters:
- WIDTH, 32, operand and HI/LO register width; must be at least 4.
- CNTW, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  issue request; sampled only when busy=0.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
- a  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- b  in  WIDTH  rt operand: multiplier or divisor.
- busy  out  1  high while a mul/div is in flight; pipeline stalls MFHI/MFLO and new issues.
- done  out  1  one-cycle pulse when the new HI/LO first become visible.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, reset=1): hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0. Reset asserted mid-operation aborts immediately; the partial result is discarded.
- FSM states: IDLE, RUN, FIX.
- IDLE, start=1, op MTHI/MTLO: hi or lo ← a at that edge; busy and done stay 0; stay in IDLE.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU, edge 0:
  - Latch operand magnitudes. Signed ops take two's-complement abs; unsigned ops take the raw value.
  - Latch the sign flags: quotient/product negative = sign(a) XOR sign(b); remainder negative = sign(a). Sign flags are 0 for unsigned ops.
  - Clear the accumulator and set counter=0.
  - busy=1; go to RUN.
  - Exception: DIV/DIVU with b=0 goes directly to FIX.
- IDLE, op 6-7: ignored.
- RUN, multiply: each edge, if multiplier LSB=1 then add the multiplicand into the upper half of the 2·WIDTH accumulator (WIDTH+1-bit sum); shift right 1.
- RUN, divide: restoring divide; shift {rem,quot} left 1; trial-subtract the divisor; on non-negative, keep the difference and set quotient LSB.
- RUN: counter increments each edge; at counter=WIDTH-1 go to FIX. RUN occupies exactly WIDTH edges.
- FIX, one edge: apply sign correction (negate product, quotient and/or remainder as flagged) and write {hi,lo}.
  - Multiply: {hi,lo} = 2·WIDTH product.
  - Divide: lo = quotient, hi = remainder.
  - Set done=1 for this one cycle, set busy=0, return to IDLE.
- Latency: start sampled at edge 0; hi/lo and done visible after edge WIDTH+1. Divide by zero: visible after edge 1.
- Divide by zero: hi = a (unmodified dividend), lo = all ones. Applies to both signed and unsigned; no sign correction.
- Signed overflow, DIV of −2^(WIDTH−1) by −1: lo = −2^(WIDTH−1), hi = 0. This falls out of the magnitude arithmetic; no trap.
- start while busy=1: ignored, including MTHI/MTLO. The pipeline must hold the instruction.
- start may be asserted in the same cycle done=1. The FSM is already IDLE, so it is accepted at the next edge.
- hi/lo are unchanged during RUN; intermediate values never appear on them.
- All arithmetic is modulo its declared width; no X propagation on unused ops.

Decomposition:
- Package mdu_pkg holds:
  - typedef enum logic [2:0] mdu_op_t with the op encodings above;
  - typedef enum logic [1:0] mdu_state_t {IDLE, RUN, FIX};
  - function negate_if(value, flag).
- Sub-module mdu_div_step: one combinational restoring-divide iteration (inputs rem, quot, divisor; outputs next rem/quot), WIDTH-parametrised.
- The multiply step is inline.

Test Plan:
- Reset mid-run: MULTU a=5, b=7; assert reset after 10 cycles → hi=0, lo=0, busy=0, done=0 immediately. A following MULTU 5×7 → lo=35, hi=0, done after edge 33.
- MULT a=−3 (0xFFFFFFFD), b=4 → hi=0xFFFFFFFF, lo=0xFFFFFFF4. busy high for 33 cycles; done is a single-cycle pulse.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Same operands with MULT → hi=0, lo=1.
- Signed divides:
  - DIV a=−7, b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
  - DIVU a=7, b=2 → lo=3, hi=1.
  - DIV 0x80000000 / −1 → lo=0x80000000, hi=0.
- Divide by zero: DIVU a=0x1234, b=0 → hi=0x1234, lo=0xFFFFFFFF, done after edge 1, busy high for one cycle only.
- Handshake:
  - MTHI a=0xAA while busy → ignored, hi unchanged after completion.
  - MTLO a=0x55 in IDLE → lo=0x55 next cycle, done stays 0.
  - start asserted on the done cycle → accepted at the next edge.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Op and state encodings are fixed because the decode stage and the debug tooling both rely on them.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

  // negate_if works on a fixed wide vector; callers zero-extend and keep the low bits.
  // This supports WIDTH up to NEG_MAXW/2 - 1.
  localparam int NEG_MAXW = 256;

  function automatic logic [NEG_MAXW-1:0] negate_if(input logic [NEG_MAXW-1:0] value,
                                                    input logic                flag);
    return flag ? ((~value) + NEG_MAXW'(1)) : value;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide iteration: shift {rem,quot} left, trial-subtract the divisor,
// and keep the difference only when it does not go negative.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    rem_sh = {rem_i, quot_i[WIDTH-1]};
    diff   = rem_sh - {1'b0, divisor_i};
    // rem_sh < 2*divisor, so the top bit of diff is exactly the borrow.
    if (diff[WIDTH]) begin
      rem_o  = rem_sh[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o  = diff[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Handshake: start is sampled only while busy=0; done pulses for one cycle when HI/LO update.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_t       state_q;
  logic [CNTW-1:0]  cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic             is_div_q;
  logic             qneg_q;
  logic             rneg_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  mdu_op_t          op_t;
  logic             signed_op;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    op_t      = mdu_op_t'(op);
    signed_op = (op_t == OP_MULT) || (op_t == OP_DIV);
    a_mag     = (signed_op && a[WIDTH-1]) ? ((~a) + WIDTH'(1)) : a;
    b_mag     = (signed_op && b[WIDTH-1]) ? ((~b) + WIDTH'(1)) : b;
  end

  // Multiply keeps the multiplier in quot_q and accumulates the product top half in rem_q.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quot_d;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (mcand_q),
    .rem_o     (div_rem),
    .quot_o    (div_quot)
  );

  always_comb begin
    mul_sum = {1'b0, rem_q} + (quot_q[0] ? {1'b0, mcand_q} : '0);
    if (is_div_q) begin
      rem_d  = div_rem;
      quot_d = div_quot;
    end else begin
      {rem_d, quot_d} = {mul_sum, quot_q[WIDTH-1:1]};
    end
  end

  logic [NEG_MAXW-1:0] prod_w;
  logic [NEG_MAXW-1:0] quot_w;
  logic [NEG_MAXW-1:0] rem_w;
  logic [WIDTH-1:0]    fix_hi;
  logic [WIDTH-1:0]    fix_lo;
  logic                unused_wide;

  always_comb begin
    prod_w = negate_if(NEG_MAXW'({rem_q, quot_q}), qneg_q);
    quot_w = negate_if(NEG_MAXW'(quot_q), qneg_q);
    rem_w  = negate_if(NEG_MAXW'(rem_q), rneg_q);
    if (is_div_q) begin
      fix_hi = rem_w[WIDTH-1:0];
      fix_lo = quot_w[WIDTH-1:0];
    end else begin
      fix_hi = prod_w[2*WIDTH-1:WIDTH];
      fix_lo = prod_w[WIDTH-1:0];
    end
  end

  assign unused_wide = ^{prod_w[NEG_MAXW-1:2*WIDTH], quot_w[NEG_MAXW-1:WIDTH],
                         rem_w[NEG_MAXW-1:WIDTH]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op_t)
              OP_MTHI: hi_q <= a;
              OP_MTLO: lo_q <= a;
              OP_MULT, OP_MULTU: begin
                mcand_q  <= a_mag;
                quot_q   <= b_mag;
                rem_q    <= '0;
                is_div_q <= 1'b0;
                qneg_q   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                rneg_q   <= 1'b0;
                cnt_q    <= '0;
                busy_q   <= 1'b1;
                state_q  <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                is_div_q <= 1'b1;
                cnt_q    <= '0;
                busy_q   <= 1'b1;
                if (b == '0) begin
                  // Divide by zero: FIX passes these through untouched (hi=a, lo=all ones).
                  mcand_q <= '0;
                  rem_q   <= a;
                  quot_q  <= '1;
                  qneg_q  <= 1'b0;
                  rneg_q  <= 1'b0;
                  state_q <= FIX;
                end else begin
                  mcand_q <= b_mag;
                  rem_q   <= '0;
                  quot_q  <= a_mag;
                  qneg_q  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                  rneg_q  <= signed_op & a[WIDTH-1];
                  state_q <= RUN;
                end
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          cnt_q  <= cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: an arithmetic reference model checked every cycle, plus directed
// vectors with literal HI/LO/latency expectations.
`timescale 1ns/1ps
module tb_mdu_seq;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op    = 3'd6;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  mdu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit en_cmp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_hi, m_lo, r_hi, r_lo;
  bit           m_busy, m_done;
  int           pend;

  function automatic void model_result(input logic [2:0] o, input logic [W-1:0] x,
                                       input logic [W-1:0] y,
                                       output logic [W-1:0] rh, output logic [W-1:0] rl);
    longint          sx, sy, sp;
    longint unsigned ux, uy, up;
    rh = '0;
    rl = '0;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      3'd0: begin
        sp = sx * sy;
        {rh, rl} = sp;
      end
      3'd1: begin
        up = ux * uy;
        {rh, rl} = up;
      end
      default: begin
        if (y == '0) begin
          rh = x;
          rl = '1;
        end else if (o == 3'd2) begin
          sp = sx / sy;
          rl = sp[W-1:0];
          sp = sx % sy;
          rh = sp[W-1:0];
        end else begin
          up = ux / uy;
          rl = up[W-1:0];
          up = ux % uy;
          rh = up[W-1:0];
        end
      end
    endcase
  endfunction

  // A mul/div result lands WIDTH+1 edges after acceptance (1 edge for divide by zero).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi   = '0;
      m_lo   = '0;
      m_busy = 1'b0;
      m_done = 1'b0;
      pend   = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        pend--;
        if (pend == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_hi   = r_hi;
          m_lo   = r_lo;
        end
      end else if (start) begin
        if (op <= 3'd3) begin
          model_result(op, a, b, r_hi, r_lo);
          m_busy = 1'b1;
          pend   = (op >= 3'd2 && b == '0) ? 1 : W + 1;
        end else if (op == 3'd4) begin
          m_hi = a;
        end else if (op == 3'd5) begin
          m_lo = a;
        end
      end
    end
  end

  // ---------------- per-cycle scoreboard compare ----------------
  always @(negedge clk) begin
    if (en_cmp) begin
      chk("cyc_busy", 64'(busy), 64'(m_busy));
      chk("cyc_done", 64'(done), 64'(m_done));
      chk("cyc_hi", 64'(hi), 64'(m_hi));
      chk("cyc_lo", 64'(lo), 64'(m_lo));
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd6;
  endtask

  task automatic wait_done(output int lat, output int bcyc);
    bcyc = busy ? 1 : 0;
    lat  = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (busy) bcyc++;
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout @%0t: got no done, expected done within 200 cycles", $time);
    end
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el,
                     input int elat, output int bcyc);
    int lat;
    issue(o, x, y);
    wait_done(lat, bcyc);
    chk({name, "_lat"}, 64'(lat), 64'(elat));
    chk({name, "_hi"}, 64'(hi), 64'(eh));
    chk({name, "_lo"}, 64'(lo), 64'(el));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int bc, lat;
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset  = 1'b0;
    en_cmp = 1'b1;
    @(negedge clk);

    // Reset in the middle of a multiply
    issue(3'd1, 32'd5, 32'd7);
    repeat (10) @(negedge clk);
    en_cmp = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset  = 1'b0;
    en_cmp = 1'b1;
    @(negedge clk);
    run("multu_5x7", 3'd1, 32'd5, 32'd7, 32'd0, 32'd35, 33, bc);

    @(negedge clk);
    run("mult_m3x4", 3'd0, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 33, bc);
    chk("mult_busy_cycles", 64'(bc), 64'd33);
    @(negedge clk);
    chk("done_pulse_len", 64'(done), 64'd0);

    run("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 33, bc);
    // Issued on the done cycle of the previous op
    run("mult_m1xm1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 33, bc);
    chk("b2b_busy_cycles", 64'(bc), 64'd33);

    run("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, bc);
    run("divu_7_2", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 33, bc);
    run("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, bc);
    run("div_100_m7", 3'd2, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 33, bc);
    run("divu_big_16", 3'd3, 32'hFFFF_FFFF, 32'd16, 32'hF, 32'h0FFF_FFFF, 33, bc);
    run("mult_mixed", 3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 33, bc);

    run("divu_by0", 3'd3, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1, bc);
    chk("div0_busy_cycles", 64'(bc), 64'd1);
    run("div_by0", 3'd2, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1, bc);

    // MTHI while busy must be dropped
    @(negedge clk);
    issue(3'd1, 32'd2, 32'd3);
    issue(3'd4, 32'hAA, 32'd0);
    wait_done(lat, bc);
    chk("mthi_busy_lat", 64'(lat), 64'd32);
    chk("mthi_busy_hi", 64'(hi), 64'd0);
    chk("mthi_busy_lo", 64'(lo), 64'd6);

    @(negedge clk);
    issue(3'd5, 32'h55, 32'd0);
    chk("mtlo_lo", 64'(lo), 64'h55);
    chk("mtlo_done", 64'(done), 64'd0);
    chk("mtlo_busy", 64'(busy), 64'd0);
    issue(3'd4, 32'hBEEF, 32'd0);
    chk("mthi_hi", 64'(hi), 64'hBEEF);
    issue(3'd7, 32'h1, 32'h1);
    chk("nop_busy", 64'(busy), 64'd0);

    repeat (3) @(negedge clk);
    en_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog @%0t: got simulation still running, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
